// File: rtl/fifo_ctrl_1k_pkg.sv
// Shared sizing and types for the 1K x 16 FIFO controller.
// Holds depth, address/data/count widths and pointer/word types.
package fifo_pkg;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int DW    = 16;
    localparam int CW    = 11;

    typedef logic [DW-1:0] word_t;
    // One extra bit over the RAM address so wrap is natural at 2047->0.
    typedef logic [AW:0]   ptr_t;

endpackage

// File: rtl/fifo_ctrl_1k_if.sv
// Bus bundle for the FIFO controller: write/read handshakes, RAM port, count.
// slave = controller side, master = upstream/downstream/RAM side.
interface fifo_ctrl_1k_if;
    import fifo_pkg::*;

    logic          i_wr_valid;
    word_t         i_wr_data;
    logic          o_wr_ready;
    logic          o_rd_valid;
    word_t         o_rd_data;
    logic          i_rd_ready;
    logic          o_mem_w_en;
    logic [AW-1:0] o_mem_w_addr;
    word_t         o_mem_d_in;
    logic [AW-1:0] o_mem_r_addr;
    word_t         i_mem_d_out;
    logic [CW-1:0] o_count;

    modport slave (
        input  i_wr_valid, i_wr_data, i_rd_ready, i_mem_d_out,
        output o_wr_ready, o_rd_valid, o_rd_data,
        output o_mem_w_en, o_mem_w_addr, o_mem_d_in, o_mem_r_addr,
        output o_count
    );

    modport master (
        output i_wr_valid, i_wr_data, i_rd_ready, i_mem_d_out,
        input  o_wr_ready, o_rd_valid, o_rd_data,
        input  o_mem_w_en, o_mem_w_addr, o_mem_d_in, o_mem_r_addr,
        input  o_count
    );

endinterface

// File: rtl/fifo_ctrl_1k_out_buf.sv
// Two-entry output buffer holding words returned from the RAM.
// Ports: clk, rst_n, push/din (RAM return), pop, head (oldest word), count.
module fifo_out_buf
    import fifo_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  word_t      din,
    input  logic       pop,
    output word_t      head,
    output logic [1:0] count
);

    logic [1:0][DW-1:0] mem;
    logic               wp;
    logic               rp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem   <= '0;
            wp    <= 1'b0;
            rp    <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                mem[wp] <= din;
                wp      <= ~wp;
            end
            if (pop) begin
                rp <= ~rp;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head = mem[rp];

endmodule

// File: rtl/fifo_ctrl_1k.sv
// First-word fall-through FIFO controller over an external 1K x 16 RAM.
// Ports: i_clk, i_rst_n (async, active low), bus (handshakes, RAM, count).
module fifo_ctrl_1k
    import fifo_pkg::*;
(
    input  logic           i_clk,
    input  logic           i_rst_n,
    fifo_ctrl_1k_if.slave  bus
);

    ptr_t          wr_ptr;
    ptr_t          rd_ptr;
    logic [CW-1:0] mem_cnt;
    logic          inflight;
    logic [1:0]    buf_cnt;
    logic          push;
    logic          pop;
    logic          issue;
    logic [2:0]    occ;

    // Ready depends only on registered state; gated low while in reset
    // so no write strobe reaches the RAM.
    assign bus.o_wr_ready = i_rst_n && (mem_cnt < CW'(DEPTH));
    assign bus.o_rd_valid = (buf_cnt != 2'd0);

    assign push = bus.i_wr_valid && bus.o_wr_ready;
    assign pop  = bus.o_rd_valid && bus.i_rd_ready;

    // Slots the buffer will hold after this edge, counting the word in
    // flight; pop only happens with buf_cnt >= 1 so this cannot underflow.
    assign occ   = {1'b0, buf_cnt} + {2'b0, inflight} - {2'b0, pop};
    assign issue = (mem_cnt != '0) && (occ < 3'd2);

    assign bus.o_mem_w_en   = push;
    assign bus.o_mem_w_addr = wr_ptr[AW-1:0];
    assign bus.o_mem_d_in   = bus.i_wr_data;
    assign bus.o_mem_r_addr = rd_ptr[AW-1:0];

    assign bus.o_count = mem_cnt + CW'(inflight) + CW'(buf_cnt);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mem_cnt  <= '0;
            inflight <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr + ptr_t'(push);
            rd_ptr   <= rd_ptr + ptr_t'(issue);
            mem_cnt  <= mem_cnt + CW'(push) - CW'(issue);
            inflight <= issue;
        end
    end

    fifo_out_buf u_buf (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (inflight),
        .din   (bus.i_mem_d_out),
        .pop   (pop),
        .head  (bus.o_rd_data),
        .count (buf_cnt)
    );

endmodule
